// File: rtl/vs_fp_dot_acc.sv
// Streaming Q-format inner-product engine: a*b rescaled by Q, accumulated with
// per-step saturation, one saturated sum per vector marked by in_last.
module vs_fp_dot_acc #(
  parameter int Q     = 15,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_a,
  input  logic signed [31:0]  in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [31:0]  out_sum,
  output logic                out_sat,
  output logic [CNT_W-1:0]    out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Clamp limits are symmetric so the accumulator never reaches 0x80000000.
  localparam logic signed [64:0] SUM_MAX = 65'sd2147483647;
  localparam logic signed [64:0] SUM_MIN = -65'sd2147483647;
  localparam logic signed [31:0] ACC_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] ACC_MIN = 32'sh8000_0001;

  state_t state_q, state_d;

  logic               accept;
  logic               out_hs;
  logic signed [63:0] prod_full;

  logic               s1_valid;
  logic               s1_last;
  logic signed [63:0] s1_p;

  logic signed [31:0] acc_q, acc_d;
  logic               sat_q, sat_set;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [64:0] sum_wide;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? DRAIN : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        // The last product sits in stage 1 and lands in acc on this edge.
        if (s1_valid && s1_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: full-precision product, floor-rescaled by Q
  // ---------------------------------------------------------------------------
  assign prod_full = 64'(in_a) * 64'(in_b);

  // NOTE: only control and datapath registers exist here (no memories), so
  // all of them are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && in_last;
      if (accept) s1_p <= prod_full >>> Q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating accumulate
  // ---------------------------------------------------------------------------
  assign sum_wide = 65'(acc_q) + 65'(s1_p);

  always_comb begin
    acc_d   = acc_q;
    sat_set = 1'b0;
    if (s1_valid) begin
      if (sum_wide > SUM_MAX) begin
        acc_d   = ACC_MAX;
        sat_set = 1'b1;
      end else if (sum_wide < SUM_MIN) begin
        acc_d   = ACC_MIN;
        sat_set = 1'b1;
      end else begin
        acc_d   = sum_wide[31:0];
      end
    end
  end

  // Stage 1 is always empty during HOLD, so the handshake clear never races
  // an accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else if (out_hs) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_q | sat_set;
      if (accept && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_sum   = acc_q;
  assign out_sat   = sat_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_vs_fp_dot_acc.sv
// Self-checking bench for vs_fp_dot_acc: directed corner vectors plus random
// vectors compared against an arithmetic reference model.
module tb_vs_fp_dot_acc;

  localparam int     Q     = 15;
  localparam int     CNT_W = 16;
  localparam longint SCALE = longint'(1) << Q;
  localparam longint LIM   = 64'sd2147483647;

  logic              clk       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_last   = 1'b0;
  logic              out_ready = 1'b0;
  logic [31:0]       in_a      = '0;
  logic [31:0]       in_b      = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_sat;
  logic [31:0]       out_sum;
  logic [CNT_W-1:0]  out_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] va [64];
  logic [31:0] vb [64];

  vs_fp_dot_acc #(.Q(Q), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer product, floor division by 2^Q, clamp after each add.
  function automatic void model(input int n, output logic [31:0] sum, output logic sat);
    longint acc, prod, q, t;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      prod = longint'($signed(va[i])) * longint'($signed(vb[i]));
      q = prod / SCALE;
      if (prod < 0 && (prod % SCALE) != 0) q = q - 1;
      t = acc + q;
      if (t > LIM) begin
        acc = LIM;
        sat = 1'b1;
      end else if (t < -LIM) begin
        acc = -LIM;
        sat = 1'b1;
      end else begin
        acc = t;
      end
    end
    sum = 32'(acc);
  endfunction

  // Starts and returns just after a falling edge; the pair is taken on the
  // rising edge in between.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      input int bubbles);
    int waited;
    in_valid = 1'b0;
    repeat (bubbles) @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else           @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input int n, input int max_bubble, input int hold);
    logic [31:0] es;
    logic        esat;
    model(n, es, esat);
    for (int i = 0; i < n; i++)
      send(va[i], vb[i], (i == n - 1), (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("sum", 64'(out_sum), 64'(es));
    check("sat", 64'(out_sat), 64'(esat));
    check("count", 64'(out_count), 64'(n));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      in_last  = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_sum", 64'(out_sum), 64'(es));
      check("hold_sat", 64'(out_sat), 64'(esat));
      check("hold_count", 64'(out_count), 64'(n));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
    check("post_hs_count", 64'(out_count), 64'd0);
    check("post_hs_sat", 64'(out_sat), 64'd0);
  endtask

  initial begin
    int n, v;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(out_sum), 64'd0);
    check("rst_sat", 64'(out_sat), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    va[0] = 32'h0001_0000; vb[0] = 32'h0001_8000; run_vec(1, 0, 0);
    for (int i = 0; i < 4; i++) begin va[i] = 32'h0000_4000; vb[i] = 32'h0000_4000; end
    run_vec(4, 3, 0);
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; run_vec(1, 0, 0);
    va[0] = 32'h0000_0001; vb[0] = 32'h0000_0001; run_vec(1, 0, 0);
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h7FFF_FFFF; run_vec(1, 0, 0);
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h8000_0001; run_vec(1, 0, 0);
    va[0] = 32'h0000_8000; vb[0] = 32'h0000_8000; run_vec(1, 0, 0);

    for (int i = 0; i < 3; i++) begin va[i] = 32'h0000_6000; vb[i] = 32'hFFFF_3000; end
    run_vec(3, 1, 5);

    // Reset in the middle of a vector: the partial result must vanish.
    send(32'h0001_0000, 32'h0001_0000, 1'b0, 0);
    send(32'h0001_0000, 32'h0001_0000, 1'b0, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(out_sum), 64'd0);
    check("midrst_count", 64'(out_count), 64'd0);
    check("midrst_sat", 64'(out_sat), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_out", 64'(out_valid), 64'd0);
    end
    va[0] = 32'h0000_8000; vb[0] = 32'h0000_8000; run_vec(1, 0, 0);

    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          va[i] = $urandom;
          vb[i] = $urandom;
        end else begin
          v = int'($urandom_range(0, 2097151)) - 1048576; va[i] = 32'(v);
          v = int'($urandom_range(0, 2097151)) - 1048576; vb[i] = 32'(v);
        end
      end
      run_vec(n, 2, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
